// File: rtl/dspn_host_master_if.sv
// Host-port bundle between a requester, dspn_host_master and a DSPn.
// Request/response handshake plus the DSP's byte-wide strobed pins.
interface dspn_host_master_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        RSP_TIMEOUT;
  logic        A0;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [7:0]  DO;
  logic [7:0]  DI;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_WDATA, DI,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
    output A0, CS_N, RD_N, WR_N, DO
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_WDATA, DI,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
    input  A0, CS_N, RD_N, WR_N, DO
  );
endinterface

// File: rtl/dspn_host_master.sv
// Host-side initiator for the DSPn host port: polls RQM, then
// moves a 16-bit word as one or two strobed byte accesses.
module dspn_host_master #(
  parameter int STROBE_LEN = 4,
  parameter int GAP_LEN    = 2,
  parameter int POLL_LIMIT = 1023
) (
  input logic CLK,
  input logic RST,
  input logic CE,
  dspn_host_master_if.master bus
);
  localparam int CMAX = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int PW   = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] STB_END = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_LEN - 1);
  localparam logic [PW-1:0] PLIM    = PW'(POLL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    PH_POLL, PH_LO, PH_HI
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  phase_t        nxt_q, nxt_d;
  logic          fin_q, fin_d;
  logic          to_q, to_d;
  logic          drc_q, drc_d;
  logic          wr_q, wr_d;
  logic [15:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rto_q, rto_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      phase_q <= PH_POLL;
      nxt_q   <= PH_POLL;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
      drc_q   <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
      rto_q   <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      phase_q <= phase_d;
      nxt_q   <= nxt_d;
      fin_q   <= fin_d;
      to_q    <= to_d;
      drc_q   <= drc_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
      rto_q   <= rto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nxt_d   = nxt_q;
    fin_d   = fin_q;
    to_d    = to_q;
    drc_d   = drc_q;
    wr_d    = wr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    rdata_d = rdata_q;
    rto_d   = rto_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          state_d = S_SETUP;
          phase_d = PH_POLL;
          wr_d    = bus.REQ_WRITE;
          data_d  = bus.REQ_WRITE ? bus.REQ_WDATA : 16'h0000;
          pcnt_d  = '0;
          fin_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt_q == STB_END) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          // DI is taken only here, in the last strobe cycle
          unique case (phase_q)
            PH_POLL: begin
              if (bus.DI[7]) begin
                drc_d  = bus.DI[2];
                pcnt_d = '0;
                nxt_d  = PH_LO;
              end else begin
                pcnt_d = pcnt_q + PW'(1);
                nxt_d  = PH_POLL;
                if (pcnt_q + PW'(1) == PLIM) begin
                  fin_d = 1'b1;
                  to_d  = 1'b1;
                end
              end
            end
            PH_LO: begin
              if (!wr_q) data_d[7:0] = bus.DI;
              fin_d = drc_q;
              nxt_d = PH_HI;
            end
            PH_HI: begin
              if (!wr_q) data_d[15:8] = bus.DI;
              fin_d = 1'b1;
            end
            default: fin_d = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (fin_q) begin
            state_d = S_RESP;
            rto_d   = to_q;
            rdata_d = (to_q || wr_q) ? 16'h0000 : data_q;
          end else begin
            state_d = S_SETUP;
            phase_d = nxt_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic act;
  logic poll;
  logic stb;

  assign act  = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                (state_q == S_HOLD);
  assign poll = (phase_q == PH_POLL);
  assign stb  = (state_q == S_STROBE);

  assign bus.REQ_READY   = (state_q == S_IDLE);
  assign bus.RSP_VALID   = (state_q == S_RESP);
  assign bus.RSP_RDATA   = rdata_q;
  assign bus.RSP_TIMEOUT = rto_q;
  assign bus.A0          = act && poll;
  assign bus.CS_N        = !act;
  assign bus.RD_N        = !(stb && (poll || !wr_q));
  assign bus.WR_N        = !(stb && !poll && wr_q);
  assign bus.DO          = (act && !poll && wr_q) ?
                           ((phase_q == PH_HI) ? data_q[15:8] : data_q[7:0]) :
                           8'h00;
endmodule

// File: tb/tb_dspn_host_master.sv
// Randomized bench for dspn_host_master against a behavioural DSP
// port model and a request-level expectation model.
module tb_dspn_host_master;
  localparam int STROBE_LEN = 4;
  localparam int GAP_LEN    = 2;
  localparam int POLL_LIMIT = 3;
  localparam int ACC        = STROBE_LEN + GAP_LEN + 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CE  = 1'b1;

  dspn_host_master_if bus();

  dspn_host_master #(
    .STROBE_LEN(STROBE_LEN),
    .GAP_LEN   (GAP_LEN),
    .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CE (CE),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DSP configuration for the current request
  logic [7:0]  sr_cfg    = 8'h80;
  int          nr_cfg    = 0;
  logic [15:0] dr_cfg    = 16'h0000;
  int          poll_base = 0;
  int          rd_base   = 0;

  // DSP-side observation totals
  int          poll_tot = 0;
  int          data_tot = 0;
  int          rd_tot   = 0;
  logic [7:0]  wr_log[$];

  always_comb begin
    bus.DI = 8'h00;
    if (bus.A0)
      bus.DI = ((poll_tot - poll_base) < nr_cfg) ? (sr_cfg & 8'h7F) : sr_cfg;
    else
      bus.DI = ((rd_tot - rd_base) == 1) ? dr_cfg[15:8] : dr_cfg[7:0];
  end

  int          w = 0;
  logic        prev_low = 1'b0;
  logic        abort = 1'b0;
  logic        last_a0, last_wr;
  logic [7:0]  last_do;
  logic        prev_ce = 1'b1;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_snap = '0;

  always @(negedge CLK) begin
    logic        low;
    logic [31:0] snap;
    low = !bus.RD_N || !bus.WR_N;
    if (RST) begin
      abort = 1'b1;
      w = 0;
    end
    if (low) begin
      if (CE) w++;
      last_a0 = bus.A0;
      last_wr = !bus.WR_N;
      last_do = bus.DO;
    end else if (prev_low) begin
      if (!abort) begin
        check("strobe_width", w, STROBE_LEN);
        if (last_a0) begin
          poll_tot++;
        end else begin
          data_tot++;
          if (last_wr) wr_log.push_back(last_do);
          else rd_tot++;
        end
      end
      w = 0;
    end
    if (!low && !RST) abort = 1'b0;
    prev_low = low;
    snap = {1'b0, bus.A0, bus.CS_N, bus.RD_N, bus.WR_N, bus.DO,
            bus.REQ_READY, bus.RSP_VALID, bus.RSP_TIMEOUT, bus.RSP_RDATA};
    if (!prev_ce && !prev_rst && !RST) check("frozen", snap, prev_snap);
    prev_snap = snap;
    prev_ce = CE;
    prev_rst = RST;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rnd_ce(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic do_req(input string tag, input logic wr,
                        input logic [15:0] wd, input logic [7:0] sr,
                        input int nr, input logic [15:0] dr,
                        input int ce_pct);
    logic        to_e, drc_e, acc_now, accepted, seen, ce_was;
    int          polls_e, data_e, lat_e, idx, guard, wbase, dbase;
    logic [15:0] rd_e;
    to_e    = (nr >= POLL_LIMIT);
    polls_e = to_e ? POLL_LIMIT : nr + 1;
    drc_e   = sr[2];
    data_e  = to_e ? 0 : (drc_e ? 1 : 2);
    lat_e   = 1 + ACC * (polls_e + data_e);
    rd_e    = to_e ? 16'h0000 : (drc_e ? {8'h00, dr[7:0]} : dr);

    sr_cfg    = sr;
    nr_cfg    = nr;
    dr_cfg    = dr;
    poll_base = poll_tot;
    rd_base   = rd_tot;
    wbase     = wr_log.size();
    dbase     = data_tot;

    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = wr;
    bus.REQ_WDATA = wd;
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 100) begin
      CE = rnd_ce(ce_pct);
      acc_now = CE && bus.REQ_READY;
      step();
      accepted = acc_now;
      guard++;
    end
    check({tag, "_accept"}, accepted, 1);
    bus.REQ_VALID = 1'b0;
    bus.REQ_WDATA = 16'($urandom);

    idx = 1;
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 5000) begin
      if (bus.RSP_VALID) begin
        seen = 1'b1;
      end else begin
        CE = rnd_ce(ce_pct);
        ce_was = CE;
        step();
        if (ce_was) idx++;
        guard++;
      end
    end
    check({tag, "_rsp_seen"}, seen, 1);
    check({tag, "_latency"}, idx, lat_e);
    check({tag, "_timeout"}, bus.RSP_TIMEOUT, to_e);
    if (!wr || to_e) check({tag, "_rdata"}, bus.RSP_RDATA, rd_e);
    check({tag, "_polls"}, poll_tot - poll_base, polls_e);
    check({tag, "_data_acc"}, data_tot - dbase, data_e);
    if (wr && !to_e && wr_log.size() >= wbase + data_e) begin
      check({tag, "_wr_lo"}, wr_log[wbase], wd[7:0]);
      if (!drc_e) check({tag, "_wr_hi"}, wr_log[wbase+1], wd[15:8]);
    end

    CE = 1'b1;
    step();
    check({tag, "_ready_after"}, bus.REQ_READY, 1);
    check({tag, "_valid_drop"}, bus.RSP_VALID, 0);
    check({tag, "_to_hold"}, bus.RSP_TIMEOUT, to_e);
    if (!wr || to_e) check({tag, "_rdata_hold"}, bus.RSP_RDATA, rd_e);
  endtask

  initial begin
    bus.REQ_VALID = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_WDATA = 16'h0000;
    RST = 1'b1;
    CE  = 1'b1;
    repeat (3) step();
    check("rst_ready",   bus.REQ_READY, 1);
    check("rst_valid",   bus.RSP_VALID, 0);
    check("rst_timeout", bus.RSP_TIMEOUT, 0);
    check("rst_rdata",   bus.RSP_RDATA, 0);
    check("rst_pins", {bus.A0, bus.CS_N, bus.RD_N, bus.WR_N}, 4'b0111);
    check("rst_do",      bus.DO, 0);
    RST = 1'b0;
    step();

    do_req("wr16",  1'b1, 16'hA55A, 8'h80, 0, 16'h0000, 100);
    if (wr_log.size() >= 2)
      check("wr16_dr", {wr_log[wr_log.size()-1], wr_log[wr_log.size()-2]},
            16'hA55A);
    do_req("rd16_poll", 1'b0, 16'h0000, 8'h80, 2, 16'h1234, 100);
    do_req("rd8",   1'b0, 16'h0000, 8'h84, 0, 16'hC33C, 100);
    do_req("tmo",   1'b0, 16'h0000, 8'h84, 3, 16'hFFFF, 100);
    do_req("wr_ce", 1'b1, 16'hBEEF, 8'h80, 1, 16'h0000, 50);
    do_req("wr8",   1'b1, 16'h7781, 8'h84, 1, 16'h0000, 100);

    // Reset in the middle of a status-read strobe
    begin
      logic found;
      int   rsp_cnt;
      sr_cfg = 8'h80;
      nr_cfg = 0;
      poll_base = poll_tot;
      bus.REQ_VALID = 1'b1;
      bus.REQ_WRITE = 1'b1;
      bus.REQ_WDATA = 16'h1111;
      CE = 1'b1;
      step();
      bus.REQ_VALID = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (!bus.RD_N) found = 1'b1;
        else step();
      end
      check("mid_rst_strobe_seen", found, 1);
      step();
      RST = 1'b1;
      step();
      check("mid_rst_pins", {bus.A0, bus.CS_N, bus.RD_N, bus.WR_N}, 4'b0111);
      check("mid_rst_do", bus.DO, 0);
      check("mid_rst_ready", bus.REQ_READY, 1);
      check("mid_rst_valid", bus.RSP_VALID, 0);
      step();
      RST = 1'b0;
      rsp_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (bus.RSP_VALID) rsp_cnt++;
      end
      check("mid_rst_no_rsp", rsp_cnt, 0);
      check("mid_rst_idle", bus.CS_N, 1);
    end

    for (int k = 0; k < 24; k++) begin
      logic        wr;
      logic [7:0]  sr;
      wr = 1'($urandom);
      sr = 8'($urandom) | 8'h80;
      do_req($sformatf("rnd%0d", k), wr, 16'($urandom), sr,
             int'($urandom_range(4)), 16'($urandom),
             (k % 2 == 0) ? 100 : 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dspn_host_master.md
# dspn_host_master

Host-side bus initiator for the DSPn coprocessor host port: turns 16-bit word read/write requests into byte-wide strobed accesses on the DSP's CS_N/A0/RD_N/WR_N/data pins. It sits between an internal requester (test sequencer, debug/save-state engine, or HLE glue) and a DSPn instance, standing in for the SNES CPU. Before each data phase it polls the status register until RQM is set. It then performs one byte access or two, according to the DRC bit.

## Interface
- STROBE_LEN, 4: CE-qualified cycles RD_N/WR_N held low per access; legal range ≥3, because the DSP edge-detects through a 3-stage sampler.
- GAP_LEN, 2: CE-qualified cycles with CS_N high between accesses; ≥1.
- POLL_LIMIT, 1023: maximum status polls per request before timeout; ≥1.

- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- CE  in  1  advance enable; connect to the same enable that drives the DSP's ENABLE. When CE=0, all state and outputs hold.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE; a request is accepted on REQ_VALID & REQ_READY & CE.
- REQ_WRITE  in  1  1 = write word, 0 = read word.
- REQ_WDATA  in  16  write data, captured at accept.
- RSP_VALID  out  1  one-CE-cycle completion pulse.
- RSP_RDATA  out  16  read result; valid with RSP_VALID.
- RSP_TIMEOUT  out  1  set with RSP_VALID when polling exhausted.
- A0  out  1  0 = data register, 1 = status register.
- CS_N, RD_N, WR_N  out  1 each  active-low strobes to the DSP.
- DO  out  8  write byte to the DSP's DI.
- DI  in  8  byte from the DSP's DO.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GAP, RESP.
- Access cycle: SETUP (1) → STROBE (STROBE_LEN) → HOLD (1) → GAP (GAP_LEN).
  - CS_N is low from SETUP through HOLD.
  - A0 and DO are stable from SETUP through HOLD.
  - RD_N or WR_N is low only in STROBE.
- Access length is STROBE_LEN+GAP_LEN+2 CE cycles (8 at defaults).
- Phase kinds: POLL (status read), DATA_LO, DATA_HI; tracked by a phase register alongside the state.
- POLL: A0=1, RD_N strobe.
  - DI is sampled in the last STROBE cycle. RQM = DI[7]; DRC = DI[2] (SR[10]).
  - RQM=0: increment the poll counter. If counter == POLL_LIMIT, go to RESP with TIMEOUT=1; otherwise run another POLL after GAP.
  - RQM=1: latch DRC, clear the poll counter, next phase is DATA_LO.
- DATA_LO: A0=0.
  - Write: DO = wdata[7:0], WR_N strobe.
  - Read: RD_N strobe; DI sampled in the last STROBE cycle goes to rdata[7:0].
- DATA_HI: performed only if the latched DRC=0 (16-bit mode). Same as DATA_LO using bits [15:8].
- DRC=1 (8-bit mode): DATA_HI is skipped. Reads return {8'h00, byte}; writes drop wdata[15:8].
- Each request re-polls and re-reads DRC. DRC is never cached across requests.
- RESP: RSP_VALID=1 for one CE cycle, then IDLE.
  - On timeout: RSP_RDATA=0 and no data access is issued.
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_TIMEOUT=0, RSP_RDATA=0, A0=0, CS_N=1, RD_N=1, WR_N=1, DO=0, state IDLE, counters 0.
- RST mid-access: all strobes deassert on the next edge, with no partial completion and no RSP_VALID.
- REQ_VALID while busy is ignored. REQ_WDATA may change after accept.

## Timing
- Request accepted at CE cycle t → first SETUP at t+1.
- RSP_VALID at t+1+n·(STROBE_LEN+GAP_LEN+2), where n = number of accesses:
  - 16-bit, ready at first poll: n=3 → cycle t+25 at defaults.
  - 8-bit, ready at first poll: n=2 → cycle t+17.
- REQ_READY rises the cycle after RSP_VALID. Back-to-back throughput is therefore one request per n·8+2 cycles.
- RSP_RDATA and RSP_TIMEOUT hold until the next RSP_VALID.
- No combinational path from DI to any output.

## Test plan
- Reset: assert RST for 2 cycles mid-STROBE → next cycle CS_N=RD_N=WR_N=1, A0=0, DO=0, REQ_READY=1, no RSP_VALID.
- 16-bit write of 16'hA55A, DSP model SR=16'h8000 → one A0=1 read, then WR_N strobes with DO=5A then A5 at A0=0. The DSP's DR equals 16'hA55A, RSP_VALID at t+25 with TIMEOUT=0.
- Polling: RQM=0 for 2 polls, then 1 → 3 status reads, then data accesses; RSP_VALID at t+1+5·8 for a 16-bit read.
- 8-bit read with SR=16'h8400 and DR low byte 8'h3C → single data access, RSP_RDATA=16'h003C at t+17.
- Timeout with POLL_LIMIT=3 and RQM stuck 0 → exactly 3 status reads, RSP_VALID with TIMEOUT=1, RSP_RDATA=0, no A0=0 strobe.
- CE gating: CE toggled 1-0-1 during a write → strobe widths equal STROBE_LEN CE=1 cycles, outputs frozen while CE=0, data at the DSP still correct.
